id_stage: RTL

- Decode stage directly downstream of the fetch stage. Consumes the IF/ID pipeline register (PC, instruction, pre-decoded fields, valid) and reads the 32-entry integer register file with write-through bypass from WB.
- Generates the immediate, detects load-use hazards, and drives the ID/EX pipeline register.
- Owns the register file.

---
 rtl/id_stage_pkg.sv | 53 +++++
 rtl/id_regfile.sv | 59 +++++
 rtl/id_stage.sv | 129 ++++++++++++
 3 files changed

// File: rtl/id_stage_pkg.sv
// ============================================================================
// Module      : id_stage_pkg
// Description : Shared widths, RV32 opcode constants and immediate-format
//               decode for the ID stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_stage_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_REG_NUM    = 32;
    localparam int INSTR_WIDTH    = 32;
    localparam int OPCODE_WIDTH   = 7;
    localparam int FUNC3_WIDTH    = 3;
    localparam int FUNC7_WIDTH    = 7;

    localparam logic [OPCODE_WIDTH-1:0] OP_LUI    = 7'b0110111;
    localparam logic [OPCODE_WIDTH-1:0] OP_AUIPC  = 7'b0010111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_WIDTH-1:0] OP_JALR   = 7'b1100111;
    localparam logic [OPCODE_WIDTH-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_WIDTH-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_WIDTH-1:0] OP_IMM    = 7'b0010011;
    localparam logic [OPCODE_WIDTH-1:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    function automatic imm_fmt_e imm_fmt(input logic [OPCODE_WIDTH-1:0] op);
        imm_fmt_e fmt;
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            default:                  fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_regfile.sv
// ============================================================================
// Module      : id_regfile
// Description : Integer register file, 2 async reads / 1 sync write, x0 hard
//               wired to zero, write-first bypass from WB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_regfile
    import id_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_NUM    = DEF_REG_NUM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] rs1_addr,
    input  logic [ADDR_WIDTH-1:0] rs2_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data
);

    logic [DATA_WIDTH-1:0] r_regs [REG_NUM];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we && (wr_addr != '0)) begin
            r_regs[wr_addr] <= wr_data;
        end
    end

    // Same-cycle WB data wins over the stored value so ID never sees stale data.
    function automatic logic [DATA_WIDTH-1:0] read_port(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] val;
        if (addr == '0) begin
            val = '0;
        end else if (we && (wr_addr == addr)) begin
            val = wr_data;
        end else begin
            val = r_regs[addr];
        end
        return val;
    endfunction

    always_comb begin
        rs1_data = read_port(rs1_addr);
        rs2_data = read_port(rs2_addr);
    end

endmodule

`default_nettype wire

// File: rtl/id_stage.sv
// ============================================================================
// Module      : id_stage
// Description : Decode stage: register read, immediate generation, load-use
//               hazard detection and the ID/EX pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage
    import id_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int REG_NUM    = DEF_REG_NUM
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_valid,
    input  logic [DATA_WIDTH-1:0]   id_pc,
    input  logic [INSTR_WIDTH-1:0]  id_instr,
    input  logic [OPCODE_WIDTH-1:0] id_op,
    input  logic [ADDR_WIDTH-1:0]   id_rs1,
    input  logic [ADDR_WIDTH-1:0]   id_rs2,
    input  logic [ADDR_WIDTH-1:0]   id_rd,
    input  logic [FUNC3_WIDTH-1:0]  id_func3,
    input  logic [FUNC7_WIDTH-1:0]  id_func7,
    input  logic                    flush,
    input  logic                    wb_we,
    input  logic [ADDR_WIDTH-1:0]   wb_rd,
    input  logic [DATA_WIDTH-1:0]   wb_data,
    output logic                    stall,
    output logic                    ex_valid,
    output logic [DATA_WIDTH-1:0]   ex_pc,
    output logic [DATA_WIDTH-1:0]   ex_rs1_data,
    output logic [DATA_WIDTH-1:0]   ex_rs2_data,
    output logic [DATA_WIDTH-1:0]   ex_imm,
    output logic [ADDR_WIDTH-1:0]   ex_rd,
    output logic [OPCODE_WIDTH-1:0] ex_op,
    output logic [FUNC3_WIDTH-1:0]  ex_func3,
    output logic [FUNC7_WIDTH-1:0]  ex_func7,
    output logic                    ex_memread,
    output logic                    ex_regwrite
);

    logic [DATA_WIDTH-1:0] w_rs1_data;
    logic [DATA_WIDTH-1:0] w_rs2_data;
    logic [31:0]           w_imm32;
    logic                  w_uses_rs1;
    logic                  w_uses_rs2;
    logic                  w_writes_rd;
    logic                  w_bubble;
    logic                  w_unused;

    // The opcode arrives pre-decoded, so the low instruction bits are redundant.
    assign w_unused = ^id_instr[6:0];

    id_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_NUM    (REG_NUM)
    ) u_regfile (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (id_rs1),
        .rs2_addr (id_rs2),
        .rs1_data (w_rs1_data),
        .rs2_data (w_rs2_data),
        .we       (wb_we),
        .wr_addr  (wb_rd),
        .wr_data  (wb_data)
    );

    always_comb begin
        w_imm32 = '0;
        case (imm_fmt(id_op))
            IMM_I:   w_imm32 = {{20{id_instr[31]}}, id_instr[31:20]};
            IMM_S:   w_imm32 = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
            IMM_B:   w_imm32 = {{19{id_instr[31]}}, id_instr[31], id_instr[7],
                                id_instr[30:25], id_instr[11:8], 1'b0};
            IMM_U:   w_imm32 = {id_instr[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{id_instr[31]}}, id_instr[31], id_instr[19:12],
                                id_instr[20], id_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign w_uses_rs1  = !((id_op == OP_LUI) || (id_op == OP_AUIPC) || (id_op == OP_JAL));
    assign w_uses_rs2  = (id_op == OP_REG) || (id_op == OP_STORE) || (id_op == OP_BRANCH);
    assign w_writes_rd = (id_op != OP_STORE) && (id_op != OP_BRANCH) && (id_rd != '0);

    // Only a load in EX can hazard; ex_memread is cleared by the bubble, so
    // the stall self-terminates after one cycle.
    assign stall = !rst && id_valid && ex_valid && ex_memread && (ex_rd != '0) &&
                   ((w_uses_rs1 && (id_rs1 == ex_rd)) || (w_uses_rs2 && (id_rs2 == ex_rd))) &&
                   !flush;

    assign w_bubble = flush || stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst || w_bubble) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_op       <= '0;
            ex_func3    <= '0;
            ex_func7    <= '0;
            ex_memread  <= 1'b0;
            ex_regwrite <= 1'b0;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_rs1_data <= w_rs1_data;
            ex_rs2_data <= w_rs2_data;
            ex_imm      <= DATA_WIDTH'($signed(w_imm32));
            ex_rd       <= id_rd;
            ex_op       <= id_op;
            ex_func3    <= id_func3;
            ex_func7    <= id_func7;
            ex_memread  <= id_valid && (id_op == OP_LOAD);
            ex_regwrite <= id_valid && w_writes_rd;
        end
    end

endmodule

`default_nettype wire
